// File: rtl/counter_ctrl_pkg.sv
// Shared types and default sizes for the counter_ctrl run controller.
// State encodings are visible on the state output pins, so they are fixed.
package counter_ctrl_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_PRE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/counter_ctrl_prescaler.sv
// Tick prescaler: pulses tick combinationally when enabled and pre_cnt has reached period.
// pre_cnt freezes while enable is low; clear zeroes it and has priority over enable.
module counter_ctrl_prescaler
  import counter_ctrl_pkg::*;
#(
  parameter int PRE_W = DEF_PRE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clear,
  input  logic [PRE_W-1:0] period,
  output logic             tick
);

  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic             hit;

  assign hit  = (pre_cnt_q == period);
  assign tick = enable && hit;

  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (clear) begin
      pre_cnt_d = '0;
    end else if (enable) begin
      pre_cnt_d = hit ? '0 : pre_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/counter_ctrl.sv
// Run controller for a WIDTH-bit up-counter: start/pause/stop/clear, auto-reload or one-shot.
// Define COUNTER_CTRL_PRESCALE_EN to include the programmable prescaler; otherwise one tick per RUN cycle.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int PRE_W = DEF_PRE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             clear,
  input  logic             one_shot,
  input  logic [WIDTH-1:0] limit,
  input  logic [PRE_W-1:0] prescale,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             wrap,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic [WIDTH-1:0] count_inc;
  logic             os_q, os_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;
  logic             stop_ok, start_acc, pre_en, pre_clr, tick_now;

  // Command priority is clear > stop > start > pause; stop only matters outside IDLE.
  assign stop_ok   = stop && (state_q != ST_IDLE);
  assign start_acc = start && !clear && !stop_ok &&
                     (state_q == ST_IDLE || state_q == ST_DONE);
  assign pre_en    = (state_q == ST_RUN) && !clear && !stop_ok && !pause;
  assign pre_clr   = clear || start_acc;
  assign count_inc = count_q + 1'b1;

`ifdef COUNTER_CTRL_PRESCALE_EN
  logic [PRE_W-1:0] pre_q, pre_d;

  assign pre_d = start_acc ? prescale : pre_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  counter_ctrl_prescaler #(
    .PRE_W (PRE_W)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (pre_en),
    .clear  (pre_clr),
    .period (pre_q),
    .tick   (tick_now)
  );
`else
  logic unused_pre;

  assign unused_pre = ^{prescale, pre_clr};
  assign tick_now   = pre_en;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      lim_q   <= '0;
      os_q    <= 1'b0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      lim_q   <= lim_d;
      os_q    <= os_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    lim_d   = lim_q;
    os_d    = os_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    if (clear) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else if (stop_ok) begin
      state_d = ST_IDLE;
    end else if (start_acc) begin
      lim_d   = limit;
      os_d    = one_shot;
      count_d = '0;
      state_d = ST_RUN;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (pause) begin
            state_d = ST_PAUSE;
          end else if (tick_now) begin
            tick_d = 1'b1;
            if (os_q) begin
              count_d = count_inc;
              if (count_inc == lim_q) begin
                state_d = ST_DONE;
              end
            end else if (count_q == lim_q) begin
              count_d = '0;
              wrap_d  = 1'b1;
            end else begin
              count_d = count_inc;
            end
          end
        end
        ST_PAUSE: begin
          if (!pause) begin
            state_d = ST_RUN;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    busy  = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    done  = (state_q == ST_DONE);
    state = state_q;
    count = count_q;
    tick  = tick_q;
    wrap  = wrap_q;
  end

endmodule
